// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS program loader: command codes, FSM states, default sizes.
package mips_loader_pkg;

  localparam logic [7:0] CMD_IMEM = 8'h00;
  localparam logic [7:0] CMD_DMEM = 8'h01;
  localparam logic [7:0] CMD_RF   = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'hFF;

  // Default address widths and the byte capacities they imply
  localparam int unsigned IMEM_AW_DEF = 8;
  localparam int unsigned DMEM_AW_DEF = 8;
  localparam int unsigned RF_AW_DEF   = 5;
  localparam int unsigned IMEM_CAP_DEF = 1 << IMEM_AW_DEF;
  localparam int unsigned DMEM_CAP_DEF = 1 << DMEM_AW_DEF;
  localparam int unsigned RF_CAP_DEF   = 4 << RF_AW_DEF;

  typedef enum logic [2:0] {StCmd, StLen0, StLen1, StData, StRun, StErr} state_e;

  typedef enum logic [1:0] {TgtImem, TgtDmem, TgtRf} target_e;

  // Byte capacity of a memory addressed by aw bits; scale is bytes per entry
  function automatic logic [31:0] capacity(input int unsigned aw, input int unsigned scale);
    return 32'(scale << aw);
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input port plus the memory/register-file write ports of the program loader.
interface mips_prog_loader_if #(
  parameter int unsigned IMEM_AW = 8,
  parameter int unsigned DMEM_AW = 8,
  parameter int unsigned RF_AW   = 5
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               im_we;
  logic [IMEM_AW-1:0] im_addr;
  logic               dm_we;
  logic [DMEM_AW-1:0] dm_addr;
  logic [7:0]         mem_wdata;
  logic               rf_we;
  logic [RF_AW-1:0]   rf_addr;
  logic [31:0]        rf_wdata;
  logic               cpu_rst;
  logic               error;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, dm_we, dm_addr, mem_wdata,
    input  rf_we, rf_addr, rf_wdata, cpu_rst, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, dm_we, dm_addr, mem_wdata,
    output rf_we, rf_addr, rf_wdata, cpu_rst, error
  );
endinterface

// File: rtl/le_word_packer.sv
// Assembles 32-bit words from a byte stream, least-significant byte first.
module le_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [31:0] sreg_q;
  logic [1:0]  cnt_q;
  logic        wv_q;

  // Shift bytes in from the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
    end else begin
      wv_q <= byte_valid && (cnt_q == 2'd3);
      if (byte_valid) begin
        sreg_q <= {byte_data, sreg_q[31:8]};
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

  assign word_valid = wv_q;
  assign word       = sreg_q;
endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader for IMEM/DMEM/RegFile; holds the CPU in reset until GO.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW = IMEM_AW_DEF,
  parameter int unsigned DMEM_AW = DMEM_AW_DEF,
  parameter int unsigned RF_AW   = RF_AW_DEF
) (
  input logic clk,
  input logic rst,
  mips_prog_loader_if.slave bus
);
  localparam logic [31:0] ImemCap = capacity(IMEM_AW, 1);
  localparam logic [31:0] DmemCap = capacity(DMEM_AW, 1);
  localparam logic [31:0] RfCap   = capacity(RF_AW, 4);

  state_e             state_q, state_d;
  target_e            tgt_q, tgt_d;
  logic [15:0]        len_q, len_d, off_q, off_d, len_full;
  logic [31:0]        cap_sel;
  logic               in_ready_q, in_ready_d, cpu_rst_q, cpu_rst_d, error_q, error_d;
  logic               im_we_q, im_we_d, dm_we_q, dm_we_d;
  logic [IMEM_AW-1:0] im_addr_q, im_addr_d;
  logic [DMEM_AW-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic [RF_AW-1:0]   rf_addr_q, rf_addr_d;
  logic               pk_clr, pk_valid, accept;

  assign accept = bus.in_valid && in_ready_q;

  // Next-state, write strobes and status outputs for the frame parser
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    len_d       = len_q;
    off_d       = off_q;
    im_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    dm_addr_d   = dm_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_addr_d   = rf_addr_q;
    pk_clr      = 1'b0;
    pk_valid    = 1'b0;
    len_full    = {bus.in_data, len_q[7:0]};
    case (tgt_q)
      TgtImem: cap_sel = ImemCap;
      TgtDmem: cap_sel = DmemCap;
      default: cap_sel = RfCap;
    endcase

    if (accept) begin
      unique case (state_q)
        StCmd: begin
          case (bus.in_data)
            CMD_GO:   state_d = StRun;
            CMD_IMEM: begin tgt_d = TgtImem; state_d = StLen0; end
            CMD_DMEM: begin tgt_d = TgtDmem; state_d = StLen0; end
            CMD_RF:   begin tgt_d = TgtRf;   state_d = StLen0; end
            default:  state_d = StErr;
          endcase
        end
        StLen0: begin
          len_d   = {8'h00, bus.in_data};
          state_d = StLen1;
        end
        StLen1: begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StCmd;
          end else if ({16'h0000, len_full} > cap_sel) begin
            state_d = StErr;
          end else if (tgt_q == TgtRf && len_full[1:0] != 2'b00) begin
            state_d = StErr;
          end else begin
            off_d   = '0;
            pk_clr  = 1'b1;
            state_d = StData;
          end
        end
        StData: begin
          off_d = off_q + 16'd1;
          case (tgt_q)
            TgtImem: begin
              im_we_d     = 1'b1;
              im_addr_d   = off_q[IMEM_AW-1:0];
              mem_wdata_d = bus.in_data;
            end
            TgtDmem: begin
              dm_we_d     = 1'b1;
              dm_addr_d   = off_q[DMEM_AW-1:0];
              mem_wdata_d = bus.in_data;
            end
            default: begin
              pk_valid  = 1'b1;
              rf_addr_d = off_q[RF_AW+1:2];
            end
          endcase
          if (off_q + 16'd1 == len_q) state_d = StCmd;
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d != StRun) && (state_d != StErr);
    cpu_rst_d  = (state_d != StRun);
    error_d    = (state_d == StErr);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCmd;
      tgt_q       <= TgtImem;
      len_q       <= '0;
      off_q       <= '0;
      in_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
      error_q     <= 1'b0;
      im_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      im_addr_q   <= '0;
      dm_addr_q   <= '0;
      mem_wdata_q <= '0;
      rf_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      len_q       <= len_d;
      off_q       <= off_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      error_q     <= error_d;
      im_we_q     <= im_we_d;
      dm_we_q     <= dm_we_d;
      im_addr_q   <= im_addr_d;
      dm_addr_q   <= dm_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_addr_q   <= rf_addr_d;
    end
  end

  le_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_data  (bus.in_data),
    .word_valid (bus.rf_we),
    .word       (bus.rf_wdata)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.error     = error_q;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rf_addr   = rf_addr_q;
endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized self-checking bench for mips_prog_loader against a frame-level reference model.
module tb_mips_prog_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [1:0]  kind;   // 0 IMEM, 1 DMEM, 2 REGFILE
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  always #5 clk = ~clk;

  mips_prog_loader_if bus ();

  mips_prog_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Record every write strobe, sampled away from the active edge
  always @(negedge clk) begin
    ev_t e;
    if (bus.im_we) begin
      e.kind = 2'd0; e.addr = {8'h00, bus.im_addr}; e.data = {24'h0, bus.mem_wdata};
      obs_q.push_back(e);
    end
    if (bus.dm_we) begin
      e.kind = 2'd1; e.addr = {8'h00, bus.dm_addr}; e.data = {24'h0, bus.mem_wdata};
      obs_q.push_back(e);
    end
    if (bus.rf_we) begin
      e.kind = 2'd2; e.addr = {11'h0, bus.rf_addr}; e.data = bus.rf_wdata;
      obs_q.push_back(e);
    end
  end

  // Reference: expected writes for one frame; status 0=back to CMD, 1=error, 2=GO
  task automatic model_frame(input bq_t f, output int status);
    int cmd, len, cap;
    ev_t e;
    status = 0;
    cmd = int'(f[0]);
    if (cmd == 255) begin status = 2; return; end
    if (cmd > 2) begin status = 1; return; end
    len = int'(f[1]) + 256 * int'(f[2]);
    if (len == 0) return;
    cap = (cmd == 2) ? 128 : 256;
    if (len > cap || (cmd == 2 && len % 4 != 0)) begin status = 1; return; end
    if (cmd < 2) begin
      for (int i = 0; i < len; i++) begin
        e.kind = 2'(cmd); e.addr = 16'(i); e.data = {24'h0, f[3+i]};
        exp_q.push_back(e);
      end
    end else begin
      for (int n = 0; n < len / 4; n++) begin
        e.kind = 2'd2; e.addr = 16'(n);
        e.data = {f[3+4*n+3], f[3+4*n+2], f[3+4*n+1], f[3+4*n]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send(input logic [7:0] b, input int gap_pct);
    int waited = 0;
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL send_ready_timeout in_ready got=0 exp=1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap_pct);
    foreach (f[i]) send(f[i], gap_pct);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", bus.cpu_rst); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    total++;
    if ({bus.im_we, bus.dm_we, bus.rf_we} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000", {bus.im_we, bus.dm_we, bus.rf_we});
    end
    total++;
    if ({bus.im_addr, bus.dm_addr, bus.rf_addr, bus.mem_wdata, bus.rf_wdata} !== '0) begin
      bad++; $display("FAIL reset_addr_data got=%h exp=0",
                      {bus.im_addr, bus.dm_addr, bus.rf_addr, bus.mem_wdata, bus.rf_wdata});
    end
  endtask

  task automatic test_imem();
    bq_t f = '{8'h00, 8'h08, 8'h00, 8'h20, 8'h08, 8'h22, 8'h01, 8'h24, 8'h10, 8'h43, 8'h00};
    logic [7:0] mem [256];
    logic [31:0] w0, w1;
    int st;
    do_reset();
    model_frame(f, st);
    for (int i = 0; i < 4; i++) send(f[i], 0);
    // First payload byte must appear on the write port one cycle after acceptance
    total++;
    if ({bus.im_we, bus.im_addr, bus.mem_wdata} !== {1'b1, 8'h00, 8'h20}) begin
      bad++; $display("FAIL imem_first_latency got=%h exp=%h",
                      {bus.im_we, bus.im_addr, bus.mem_wdata}, {1'b1, 8'h00, 8'h20});
    end
    for (int i = 4; i < f.size(); i++) send(f[i], 0);
    idle(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL imem_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL imem_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (obs_q[i]) if (obs_q[i].kind == 2'd0) mem[obs_q[i].addr[7:0]] = obs_q[i].data[7:0];
    w0 = {mem[3], mem[2], mem[1], mem[0]};
    w1 = {mem[7], mem[6], mem[5], mem[4]};
    total++; if (w0 !== 32'h01220820) begin bad++; $display("FAIL imem_word0 got=%h exp=01220820", w0); end
    total++; if (w1 !== 32'h00431024) begin bad++; $display("FAIL imem_word1 got=%h exp=00431024", w1); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL imem_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_regfile(input int gap_pct, input string tag);
    bq_t f = '{8'h02, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    int st;
    do_reset();
    model_frame(f, st);
    send_frame(f, gap_pct);
    idle(3);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL %s_rf_count got=%0d exp=2", tag, obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_rf_write[%0d] got=%h exp=%h", tag, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int st;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bq_t f;
      int tgt = int'($urandom_range(2));
      int len = (k == 3) ? 0 : ((tgt == 2) ? 4 * int'($urandom_range(1, 8)) : int'($urandom_range(1, 40)));
      f.push_back(8'(tgt));
      f.push_back(8'(len));
      f.push_back(8'(len >> 8));
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      exp_q.delete();
      obs_q.delete();
      model_frame(f, st);
      send_frame(f, 50);
      idle(3);
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_write[%0d] got=%h exp=%h", k, i, obs_q[i], exp_q[i]);
        end
      end
      total++;
      if ({bus.in_ready, bus.error} !== 2'b10) begin
        bad++; $display("FAIL rand%0d_status got=%b exp=10", k, {bus.in_ready, bus.error});
      end
    end
  endtask

  task automatic test_dmem_go();
    bq_t f = '{8'h01, 8'h00, 8'h01};
    int st;
    do_reset();
    for (int i = 0; i < 256; i++) f.push_back(8'($urandom));
    model_frame(f, st);
    send_frame(f, 0);
    idle(3);
    total++;
    if (obs_q.size() != 256) begin bad++; $display("FAIL dmem_count got=%0d exp=256", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        total++; bad++;
        $display("FAIL dmem_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[obs_q.size()-1].addr !== 16'h00FF) begin
        bad++; $display("FAIL dmem_last_addr got=%h exp=00ff", obs_q[obs_q.size()-1].addr);
      end
    end
    total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL pre_go_cpu_rst got=%b exp=1", bus.cpu_rst); end
    send(8'hFF, 0);
    total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("FAIL go_cpu_rst got=%b exp=0", bus.cpu_rst); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL go_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data = 8'h00;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if ({bus.in_ready, bus.cpu_rst, bus.error} !== 3'b000) begin
      bad++; $display("FAIL run_hold got=%b exp=000", {bus.in_ready, bus.cpu_rst, bus.error});
    end
  endtask

  task automatic test_errors();
    bq_t f;
    int st;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: f = '{8'h07};
        1: f = '{8'h02, 8'h06, 8'h00};
        default: f = '{8'h00, 8'h01, 8'h01};
      endcase
      do_reset();
      model_frame(f, st);
      send_frame(f, 0);
      total++;
      if ({bus.error, bus.in_ready, bus.cpu_rst} !== {(st == 1), 1'b0, 1'b1}) begin
        bad++; $display("FAIL err%0d_status got=%b exp=%b", k,
                        {bus.error, bus.in_ready, bus.cpu_rst}, {(st == 1), 1'b0, 1'b1});
      end
      bus.in_valid = 1'b1;
      bus.in_data = 8'h00;
      repeat (6) @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (obs_q.size() != 0 || bus.error !== 1'b1 || bus.cpu_rst !== 1'b1) begin
        bad++; $display("FAIL err%0d_sticky writes=%0d error=%b cpu_rst=%b exp writes=0 error=1 cpu_rst=1",
                        k, obs_q.size(), bus.error, bus.cpu_rst);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    bq_t f = '{8'h02, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    int st;
    do_reset();
    for (int i = 0; i < 5; i++) send(f[i], 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.cpu_rst} !== 2'b01) begin
      bad++; $display("FAIL mid_rst_outputs got=%b exp=01", {bus.rf_we, bus.cpu_rst});
    end
    rst = 1'b0;
    idle(2);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL mid_rst_writes got=%0d exp=0", obs_q.size()); end
    exp_q.delete();
    model_frame(f, st);
    send_frame(f, 30);
    idle(3);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL post_rst_count got=%0d exp=1", obs_q.size());
    end else if (obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL post_rst_write got=%h exp=%h", obs_q[0], exp_q[0]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_imem();
    test_regfile(0, "rf");
    test_regfile(50, "rf_gaps");
    test_random_frames();
    test_dmem_go();
    test_errors();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
